// File: rtl/pwm_pkg.sv
// pwm_pkg: register map and CTRL field positions shared by the PWM LED controller
package pwm_pkg;
  localparam logic [3:0] ADDR_CTRL      = 4'd0;
  localparam logic [3:0] ADDR_PRESC     = 4'd1;
  localparam logic [3:0] ADDR_DUTY_BASE = 4'd2;
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_FADE_LSB = 8;
  function automatic logic [3:0] duty_addr(input int ch);
    return ADDR_DUTY_BASE + 4'(ch);
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM compare with shadow/active duty and up/down triangle fade
module pwm_channel #(
  parameter int CNT_WIDTH  = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 wrap,
  input  logic                 fade,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 shadow_we,
  input  logic [CNT_WIDTH-1:0] shadow_wd,
  output logic [CNT_WIDTH-1:0] shadow,
  output logic                 pwm
);
  localparam logic IDLE_LVL = 1'(ACTIVE_LOW);
  logic [CNT_WIDTH-1:0] duty;
  logic                 down;
  logic                 step_down;
  // direction after this step: reversing at an end also makes duty move back inward
  always_comb step_down = down ? (duty != '0) : (duty == '1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      duty   <= '0;
      down   <= 1'b0;
      pwm    <= IDLE_LVL;
    end else begin
      if (shadow_we) shadow <= shadow_wd;
      if (!en) duty <= shadow;
      else if (wrap) duty <= fade ? (step_down ? duty - 1'b1 : duty + 1'b1) : shadow;
      if (!fade) down <= 1'b0;
      else if (wrap) down <= step_down;
      pwm <= en ? ((cnt < duty) ^ IDLE_LVL) : IDLE_LVL;
    end
  end
endmodule

// File: rtl/pwm_led_ctrl.sv
// pwm_led_ctrl: multi-channel LED PWM with prescaler, shadowed duty registers and fading
module pwm_led_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_WIDTH   = 8,
  parameter int PRESC_WIDTH = 16,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  logic                   en;
  logic [NUM_CH-1:0]      fade;
  logic [PRESC_WIDTH-1:0] presc;
  logic [PRESC_WIDTH-1:0] pcnt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   tick;
  logic                   wrap;
  logic [31:0]            rd_next;
  logic [CNT_WIDTH-1:0]   shadow [NUM_CH];
  logic                   unused_wr;
  assign unused_wr   = ^wr_data;
  assign tick        = en && (pcnt == presc);
  assign wrap        = tick && (cnt == CNT_LAST);
  assign period_tick = wrap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en    <= 1'b0;
      fade  <= '0;
      presc <= '0;
    end else if (wr_en) begin
      if (wr_addr == ADDR_CTRL) begin
        en   <= wr_data[CTRL_EN_BIT];
        fade <= wr_data[CTRL_FADE_LSB +: NUM_CH];
      end
      if (wr_addr == ADDR_PRESC) presc <= wr_data[PRESC_WIDTH-1:0];
    end
  end
  // a prescaler already past a newly written compare value rolls over naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (!en) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end
  always_comb begin
    rd_next = '0;
    if (rd_addr == ADDR_CTRL) begin
      rd_next[CTRL_EN_BIT]             = en;
      rd_next[CTRL_FADE_LSB +: NUM_CH] = fade;
    end
    if (rd_addr == ADDR_PRESC) rd_next[PRESC_WIDTH-1:0] = presc;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_addr == duty_addr(i)) rd_next[CNT_WIDTH-1:0] = shadow[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else rd_data <= rd_next;
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .wrap     (wrap),
      .fade     (fade[g]),
      .cnt      (cnt),
      .shadow_we(wr_en && (wr_addr == duty_addr(g))),
      .shadow_wd(wr_data[CNT_WIDTH-1:0]),
      .shadow   (shadow[g]),
      .pwm      (pwm_out[g])
    );
  end
endmodule

// File: tb/tb_pwm_led_ctrl.sv
// tb_pwm_led_ctrl: directed checks of duty, shadow timing, fade, prescaler and reset
module tb_pwm_led_ctrl;
  logic        clk = 0, clk_run = 0, rst_n = 1, wr_en = 0;
  logic [3:0]  wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] rd_data;
  logic [2:0]  pwm_out;
  logic        period_tick;
  int vectors = 0, miscompares = 0;
  int on0, on1, on2, tk, c;
  logic [31:0] d;

  pwm_led_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk); wr_en = 1; wr_addr = a; wr_data = v;
    @(negedge clk); wr_en = 0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk); rd_addr = a;
    @(negedge clk); v = rd_data;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!period_tick && n < 5000);
    if (!period_tick) begin
      vectors++; miscompares++;
      $display("FAIL wait_tick: no period_tick within %0d cycles", n);
    end
  endtask

  task automatic align();
    int n;
    wait_tick(n);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic clr();
    on0 = 0; on1 = 0; on2 = 0; tk = 0;
  endtask

  task automatic sample(input int n);
    for (int k = 0; k < n; k++) begin
      if (!pwm_out[0]) on0++;
      if (!pwm_out[1]) on1++;
      if (!pwm_out[2]) on2++;
      if (period_tick) tk++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #3;
    vectors++; if (pwm_out !== 3'b111) begin miscompares++; $display("FAIL reset_pwm: got %b expected 111", pwm_out); end
    vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL reset_rd: got %0h expected 0", rd_data); end
    vectors++; if (period_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", period_tick); end
    clk_run = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    clr(); sample(300);
    vectors++; if (tk !== 0) begin miscompares++; $display("FAIL idle_tick: got %0d expected 0", tk); end
    vectors++; if (on0 + on1 + on2 !== 0) begin miscompares++; $display("FAIL idle_pwm: got %0d on-samples expected 0", on0 + on1 + on2); end
  endtask

  task automatic test_basic_duty();
    wr(1, 0); wr(2, 64); wr(3, 0); wr(4, 255); wr(0, 1);
    align(); clr(); sample(255);
    vectors++; if (on0 !== 64) begin miscompares++; $display("FAIL basic_on0: got %0d expected 64", on0); end
    vectors++; if (tk !== 1) begin miscompares++; $display("FAIL basic_ticks: got %0d expected 1", tk); end
    wait_tick(c); wait_tick(c);
    vectors++; if (c !== 255) begin miscompares++; $display("FAIL basic_period: got %0d expected 255", c); end
  endtask

  task automatic test_extremes();
    align(); clr(); sample(765);
    vectors++; if (on1 !== 0) begin miscompares++; $display("FAIL extreme_duty0: got %0d on expected 0", on1); end
    vectors++; if (on2 !== 765) begin miscompares++; $display("FAIL extreme_duty255: got %0d on expected 765", on2); end
    vectors++; if (tk !== 3) begin miscompares++; $display("FAIL extreme_ticks: got %0d expected 3", tk); end
  endtask

  task automatic test_shadow_timing();
    align(); clr(); sample(99);
    wr_en = 1; wr_addr = 2; wr_data = 200;
    sample(1);
    wr_en = 0;
    sample(155);
    vectors++; if (on0 !== 64) begin miscompares++; $display("FAIL shadow_cur: got %0d expected 64", on0); end
    clr(); sample(255);
    vectors++; if (on0 !== 200) begin miscompares++; $display("FAIL shadow_next: got %0d expected 200", on0); end
    rd(2, d);
    vectors++; if (d !== 32'd200) begin miscompares++; $display("FAIL shadow_read: got %0d expected 200", d); end
  endtask

  task automatic test_wrap_write();
    wait_tick(c);
    wr_en = 1; wr_addr = 2; wr_data = 30;
    @(negedge clk); wr_en = 0;
    @(negedge clk);
    clr(); sample(255);
    vectors++; if (on0 !== 200) begin miscompares++; $display("FAIL wrap_write_old: got %0d expected 200", on0); end
    clr(); sample(255);
    vectors++; if (on0 !== 30) begin miscompares++; $display("FAIL wrap_write_new: got %0d expected 30", on0); end
  endtask

  task automatic test_fade();
    wr(3, 254);
    wait_tick(c);
    wr(0, 32'h201);
    align(); clr(); sample(255);
    vectors++; if (on1 !== 255) begin miscompares++; $display("FAIL fade_p1: got %0d expected 255", on1); end
    clr(); sample(255);
    vectors++; if (on1 !== 254) begin miscompares++; $display("FAIL fade_p2: got %0d expected 254", on1); end
    clr(); sample(255);
    vectors++; if (on1 !== 253) begin miscompares++; $display("FAIL fade_p3: got %0d expected 253", on1); end
    wr(0, 1);
  endtask

  task automatic test_presc();
    wr(1, 32'hABCD_0003);
    wait_tick(c); wait_tick(c);
    vectors++; if (c !== 1020) begin miscompares++; $display("FAIL presc_period: got %0d expected 1020", c); end
    align(); clr(); sample(1020);
    vectors++; if (on0 !== 120) begin miscompares++; $display("FAIL presc_on0: got %0d expected 120", on0); end
    rd(1, d);
    vectors++; if (d !== 32'd3) begin miscompares++; $display("FAIL presc_read: got %0h expected 3", d); end
  endtask

  task automatic test_readback();
    rd(0, d);
    vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL ctrl_read: got %0h expected 1", d); end
    wr(12, 32'hFFFF_FFFF);
    rd(12, d);
    vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL unmapped_read: got %0h expected 0", d); end
    rd(5, d);
    vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL nochan_read: got %0h expected 0", d); end
    rd(4, d);
    vectors++; if (d !== 32'd255) begin miscompares++; $display("FAIL duty2_read: got %0d expected 255", d); end
    rd(0, d);
    vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL ctrl_after_unmapped: got %0h expected 1", d); end
  endtask

  task automatic test_mid_reset();
    wait_tick(c);
    wr_en = 1; wr_addr = 1; wr_data = 0;
    @(negedge clk); wr_en = 0; rd_addr = 2;
    wait_tick(c);
    repeat (51) @(negedge clk);
    vectors++; if (pwm_out !== 3'b001) begin miscompares++; $display("FAIL premid_pwm: got %b expected 001", pwm_out); end
    vectors++; if (rd_data !== 32'd30) begin miscompares++; $display("FAIL premid_rd: got %0d expected 30", rd_data); end
    #2 rst_n = 0;
    #1;
    vectors++; if (pwm_out !== 3'b111) begin miscompares++; $display("FAIL mid_reset_pwm: got %b expected 111", pwm_out); end
    vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL mid_reset_rd: got %0h expected 0", rd_data); end
    vectors++; if (period_tick !== 1'b0) begin miscompares++; $display("FAIL mid_reset_tick: got %b expected 0", period_tick); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    clr(); sample(600);
    vectors++; if (tk !== 0) begin miscompares++; $display("FAIL post_reset_tick: got %0d expected 0", tk); end
    vectors++; if (on0 + on1 + on2 !== 0) begin miscompares++; $display("FAIL post_reset_pwm: got %0d on-samples expected 0", on0 + on1 + on2); end
    rd(2, d);
    vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL post_reset_shadow: got %0d expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_extremes();
    test_shadow_timing();
    test_wrap_write();
    test_fade();
    test_presc();
    test_readback();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_led_ctrl.md
PWM_LED_CTRL -- requirements
Module: pwm_led_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent PWM channels, range 1..8.
REQ-002 Parameter CNT_WIDTH, default 8: PWM resolution in bits; MAX = 2^CNT_WIDTH-1.
REQ-003 Parameter PRESC_WIDTH, default 16: prescaler register width.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = pwm_out drives 0 when on (iCE40 RGB/LED pins).
REQ-005 clk  input  1  single system clock; all logic is on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  register write strobe, one write per cycle.
REQ-008 wr_addr  input  4  register write address.
REQ-009 wr_data  input  32  register write data.
REQ-010 rd_addr  input  4  register read address.
REQ-011 rd_data  output  32  read data, registered.
REQ-012 pwm_out  output  NUM_CH  per-channel PWM outputs, registered.
REQ-013 period_tick  output  1  one-cycle pulse on each PWM period wrap.

Function
REQ-014 The register map SHALL be as follows.
- Addr 0, CTRL: bit0 = global enable; bits[8+NUM_CH-1:8] = per-channel fade enable.
- Addr 1, PRESC: bits[PRESC_WIDTH-1:0].
- Addr 2+i, DUTY_i shadow: bits[CNT_WIDTH-1:0].
- Writes to unmapped addresses SHALL be ignored; reads of unmapped addresses SHALL return 0.
- Unused bits SHALL read as 0.
REQ-015 rd_data SHALL present the register selected by rd_addr one cycle after rd_addr is sampled; for a shadow register it SHALL return the shadow value, not the active duty.
REQ-016 Prescaler: when enabled, it SHALL count 0..PRESC; tick asserts in the cycle the count equals PRESC, then the count returns to 0.
REQ-017 PWM counter: SHALL advance on each tick through 0..MAX-1 and wrap to 0, giving a period of MAX*(PRESC+1) clocks.
REQ-018 Channel on-condition: cnt < duty_active_i; duty 0 SHALL never turn on, duty MAX SHALL always be on.
REQ-019 pwm_out_i SHALL equal the on-condition, inverted when ACTIVE_LOW=1, delayed by exactly one clock.
REQ-020 Wrap event = tick with cnt==MAX-1; period_tick SHALL assert in the same cycle as the wrap event.
REQ-021 On each wrap event, each non-fade channel SHALL load duty_active_i from its shadow register.
REQ-022 A shadow write in the wrap-event cycle SHALL NOT affect the load in that cycle; the new value takes effect at the next wrap.
REQ-023 Fade channels SHALL step duty_active once per wrap, up then down, with a per-channel direction bit.
- Direction up: at MAX the direction flips to down and duty goes to MAX-1; otherwise duty +1.
- Direction down: at 0 the direction flips to up and duty goes to 1; otherwise duty -1.
REQ-024 Setting a fade bit SHALL start fading from the current duty_active with direction up; clearing it SHALL resume shadow loading at the next wrap.
REQ-025 While enable=0, the prescaler and cnt SHALL be held at 0, period_tick SHALL be 0, all pwm_out SHALL be inactive, and duty_active SHALL track its shadow every cycle.
REQ-026 Rising enable SHALL start a period at cnt=0 using the current shadow values.
REQ-027 A PRESC write SHALL take effect on the next prescaler compare; if the prescaler count exceeds the new value, it SHALL run to its maximum and wrap.

Reset
REQ-028 While rst_n=0, all registers, shadows, duty_active, direction bits, counters and rd_data SHALL be 0, period_tick SHALL be 0, and pwm_out SHALL be inactive ({NUM_CH{ACTIVE_LOW}}), immediately and without any clock edge.
REQ-029 After rst_n deasserts, the block SHALL remain idle until CTRL.enable is written 1.

Structure
REQ-030 A package pwm_pkg SHALL hold the register address constants (CTRL, PRESC, DUTY_BASE) and the CTRL bit-position constants.
REQ-031 The per-channel compare, shadow/active duty and fade logic SHALL be one sub-module, pwm_channel, instantiated NUM_CH times by a generate loop.
- The prescaler, period counter and register file SHALL reside in pwm_led_ctrl.

Verification
REQ-032 The bench SHALL cover these directed scenarios, all with defaults (NUM_CH=3, CNT_WIDTH=8, ACTIVE_LOW=1):
- Reset: hold rst_n=0 with no clock -> pwm_out=3'b111, rd_data=0, period_tick=0.
- Basic duty: PRESC=0, DUTY_0=64, enable -> pwm_out[0] low for 64 of every 255 clocks; period_tick every 255 clocks.
- Extremes: DUTY_1=0 and DUTY_2=255 -> pwm_out[1] constantly 1 and pwm_out[2] constantly 0 across 3 periods.
- Shadow timing: write DUTY_0=200 at cnt=100 -> current period keeps 64 low clocks, next period has 200; reading DUTY_0 returns 200 one cycle after rd_addr=2.
- Fade: active duty 254, fade bit 1 set -> successive periods have 255, 254, 253 on-clocks; PRESC=3 -> period_tick every 1020 clocks.
- Mid-period reset: assert rst_n=0 at cnt=50 -> pwm_out=3'b111 immediately; after release with enable=0, no period_tick.
